// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance controller: TLBWR / TLBFILL / TLBRD / INVTLB sequencing.
// Ports: op_* / inv_* / csr_index in, op_ready/busy/inv_ill status, w_* write port, r_* read port.
module tlb_maint_ctrl #(
    parameter  int TLBNUM    = 16,
    parameter  int FILL_MODE = 0,
    localparam int IW        = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic [2:0]    op_code,
    input  logic          op_ex,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    input  logic [IW-1:0] csr_index,
    output logic          op_ready,
    output logic          busy,
    output logic          inv_ill,
    output logic          w_we,
    output logic [IW-1:0] w_index,
    output logic          w_clear,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic          r_g,
    input  logic [9:0]    r_asid,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [2:0] OP_WR   = 3'd1;
    localparam logic [2:0] OP_FILL = 3'd2;
    localparam logic [2:0] OP_RD   = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] fill_q;
    logic [15:0]   lfsr_q;
    logic [2:0]    op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;

    logic          take;
    logic          inv_legal;
    logic          inv_start;
    logic          fill_go;
    logic          last;
    logic [IW-1:0] fill_idx;
    logic          va_hit;
    logic          asid_hit;
    logic          sel;
    logic          hit;
    logic          lfsr_fb;

    // An instruction is acted on only in IDLE and only if it is not cancelled.
    assign take      = (state_q == IDLE) && op_valid && !op_ex;
    assign inv_legal = (inv_op <= 5'd6);
    assign inv_start = take && (op_code == OP_INV) && inv_legal;
    assign fill_go   = take && (op_code == OP_FILL);
    assign last      = (cnt_q == IW'(TLBNUM - 1));
    assign fill_idx  = (FILL_MODE != 0) ? lfsr_q[IW-1:0] : fill_q;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inv_start) state_d = SWEEP;
            SWEEP:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, LFSR and latched INVTLB operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            fill_q <= '0;
            lfsr_q <= 16'hACE1;
            op_q   <= '0;
            asid_q <= '0;
            vppn_q <= '0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            if (inv_start) begin
                cnt_q  <= '0;
                op_q   <= inv_op[2:0];
                asid_q <= inv_asid;
                vppn_q <= inv_vppn;
            end else if (state_q == SWEEP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fill_go) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Match of the entry currently on the read port against the latched operands.
    // A 2MB page (ps=21) only compares the VPPN bits above the page offset.
    assign va_hit   = (r_ps == 6'd21) ? (r_vppn[18:9] == vppn_q[18:9])
                                      : (r_vppn == vppn_q);
    assign asid_hit = (r_asid == asid_q);

    always_comb begin
        sel = 1'b0;
        case (op_q)
            3'd0, 3'd1: sel = 1'b1;
            3'd2:       sel = r_g;
            3'd3:       sel = !r_g;
            3'd4:       sel = !r_g && asid_hit;
            3'd5:       sel = !r_g && asid_hit && va_hit;
            3'd6:       sel = (r_g || asid_hit) && va_hit;
            default:    sel = 1'b0;
        endcase
    end

    assign hit = r_e && sel;

    // Output logic; reset silences every strobe even while op inputs are live.
    always_comb begin
        op_ready = 1'b0;
        inv_ill  = 1'b0;
        w_we     = 1'b0;
        w_clear  = 1'b0;
        w_index  = csr_index;
        r_index  = csr_index;
        busy     = (state_q != IDLE);
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (op_ex) begin
                            op_ready = 1'b1;
                        end else begin
                            case (op_code)
                                OP_WR: begin
                                    w_we     = 1'b1;
                                    op_ready = 1'b1;
                                end
                                OP_FILL: begin
                                    w_we     = 1'b1;
                                    w_index  = fill_idx;
                                    op_ready = 1'b1;
                                end
                                OP_RD: begin
                                    op_ready = 1'b1;
                                end
                                OP_INV: begin
                                    if (!inv_legal) begin
                                        op_ready = 1'b1;
                                        inv_ill  = 1'b1;
                                    end
                                end
                                default: begin
                                    op_ready = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                SWEEP: begin
                    r_index = cnt_q;
                    if (hit) begin
                        w_we    = 1'b1;
                        w_clear = 1'b1;
                        w_index = cnt_q;
                    end
                end
                DONE: begin
                    op_ready = 1'b1;
                end
                default: begin
                    op_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Self-checking bench for tlb_maint_ctrl (round-robin and LFSR fill instances).
// Drives inputs #1 after posedge, samples outputs on negedge.
module tb_tlb_maint_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = '0;
    logic          op_ex = 1'b0;
    logic [4:0]    inv_op = '0;
    logic [9:0]    inv_asid = '0;
    logic [18:0]   inv_vppn = '0;
    logic [IW-1:0] csr_index = '0;

    logic          op_ready, busy, inv_ill, w_we, w_clear;
    logic [IW-1:0] w_index, r_index;
    logic          op_ready1, busy1, inv_ill1, w_we1, w_clear1;
    logic [IW-1:0] w_index1, r_index1;

    logic          r_e, r_g;
    logic [9:0]    r_asid;
    logic [18:0]   r_vppn;
    logic [5:0]    r_ps;

    logic          m_e [N];
    logic          m_g [N];
    logic [9:0]    m_asid [N];
    logic [18:0]   m_vppn [N];
    logic [5:0]    m_ps [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_maint_ctrl #(.TLBNUM(N), .FILL_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ex(op_ex), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .op_ready(op_ready), .busy(busy), .inv_ill(inv_ill),
        .w_we(w_we), .w_index(w_index), .w_clear(w_clear), .r_index(r_index),
        .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps)
    );

    tlb_maint_ctrl #(.TLBNUM(N), .FILL_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ex(op_ex), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .op_ready(op_ready1), .busy(busy1), .inv_ill(inv_ill1),
        .w_we(w_we1), .w_index(w_index1), .w_clear(w_clear1), .r_index(r_index1),
        .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps)
    );

    // TLB array model on the read port of the round-robin instance
    always_comb begin
        r_e    = m_e[r_index];
        r_g    = m_g[r_index];
        r_asid = m_asid[r_index];
        r_vppn = m_vppn[r_index];
        r_ps   = m_ps[r_index];
    end

    always @(posedge clk) begin
        if (!reset && w_we && w_clear) m_e[w_index] <= 1'b0;
    end

    typedef struct {
        logic          v;
        logic [2:0]    code;
        logic          ex;
        logic [4:0]    iop;
        logic [IW-1:0] idx;
        logic          rdy;
        logic          ill;
        logic          we;
        logic [IW-1:0] widx;
        logic          clr;
        logic [IW-1:0] ridx;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        op_valid = 1'b0;
        op_code  = '0;
        op_ex    = 1'b0;
        inv_op   = '0;
    endtask

    task automatic load_model();
        for (int i = 0; i < N; i++) begin
            m_e[i] = 1'b0; m_g[i] = 1'b0; m_asid[i] = 10'd0;
            m_vppn[i] = 19'h0; m_ps[i] = 6'd12;
        end
        m_e[2] = 1'b1;  m_g[2] = 1'b0;  m_asid[2] = 10'd5;  m_vppn[2] = 19'h12345;
        m_e[4] = 1'b1;  m_g[4] = 1'b0;  m_asid[4] = 10'd6;  m_vppn[4] = 19'h12345;
        m_e[7] = 1'b1;  m_g[7] = 1'b1;  m_asid[7] = 10'd9;  m_vppn[7] = 19'h12345;
        m_e[11] = 1'b1; m_g[11] = 1'b0; m_asid[11] = 10'd5; m_vppn[11] = 19'h12344;
        m_e[12] = 1'b1; m_g[12] = 1'b0; m_asid[12] = 10'd5; m_vppn[12] = 19'h12300;
        m_ps[12] = 6'd21;
        m_e[13] = 1'b0; m_g[13] = 1'b0; m_asid[13] = 10'd5; m_vppn[13] = 19'h12345;
    endtask

    task automatic run_inv(input string name, input logic [4:0] op,
                           input logic [9:0] asid, input logic [18:0] vppn,
                           input logic [15:0] exp_mask);
        logic [15:0] mask;
        int lat;
        int bad;
        mask = '0; lat = 0; bad = 0;
        load_model();
        csr_index = 4'd3;
        op_valid = 1'b1; op_code = 3'd4; op_ex = 1'b0;
        inv_op = op; inv_asid = asid; inv_vppn = vppn;
        @(negedge clk);
        chk({name, "_accept_rdy"}, {31'd0, op_ready}, 32'd0);
        step();
        // ignored while busy; operands must already be latched
        op_code = 3'd1; inv_asid = 10'h3FF; inv_vppn = 19'h7FFFF; inv_op = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (w_we) begin
                mask[w_index] = 1'b1;
                if (!w_clear) bad++;
            end
            if (!busy) bad++;
            if (k <= N && r_index !== IW'(k - 1)) bad++;
            if (op_ready) begin
                lat = k;
                break;
            end
            step();
        end
        chk({name, "_latency"}, lat, 32'd17);
        chk({name, "_cleared"}, {16'd0, mask}, {16'd0, exp_mask});
        chk({name, "_sweep_bad"}, bad, 32'd0);
        step();
        idle_in();
        @(negedge clk);
        chk({name, "_after_busy_rdy"}, {30'd0, busy, op_ready}, 32'd0);
        chk({name, "_after_ridx"}, {28'd0, r_index}, 32'd3);
        step();
    endtask

    initial begin
        load_model();
        vt[0]  = '{1'b1, 3'd1, 1'b0, 5'd0,  4'd3,  1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 4'd3};
        vt[1]  = '{1'b1, 3'd1, 1'b0, 5'd0,  4'd15, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd15};
        vt[2]  = '{1'b1, 3'd3, 1'b0, 5'd0,  4'd9,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9};
        vt[3]  = '{1'b1, 3'd1, 1'b1, 5'd0,  4'd5,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd5};
        vt[4]  = '{1'b1, 3'd4, 1'b1, 5'd0,  4'd2,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2};
        vt[5]  = '{1'b1, 3'd4, 1'b0, 5'd9,  4'd1,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd1};
        vt[6]  = '{1'b1, 3'd4, 1'b0, 5'd31, 4'd6,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd6};
        vt[7]  = '{1'b1, 3'd4, 1'b0, 5'd7,  4'd8,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8};
        vt[8]  = '{1'b0, 3'd1, 1'b0, 5'd0,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd4};
        vt[9]  = '{1'b1, 3'd2, 1'b1, 5'd0,  4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0};
        vt[10] = '{1'b1, 3'd2, 1'b0, 5'd0,  4'd0,  1'b1, 1'b0, 1'b1, 4'd1,  1'b0, 4'd0};
        vt[11] = '{1'b1, 3'd2, 1'b0, 5'd0,  4'd0,  1'b1, 1'b0, 1'b1, 4'd2,  1'b0, 4'd0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {28'd0, busy, inv_ill, w_we, w_clear}, 32'd0);
        chk("reset_out1", {28'd0, busy1, inv_ill1, w_we1, w_clear1}, 32'd0);

        // 17 round-robin fills straight out of reset; LFSR fill on first cycle
        step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            op_valid = 1'b1; op_code = 3'd2;
            @(negedge clk);
            chk($sformatf("fill%0d", i),
                {26'd0, op_ready, w_we, w_clear, w_index},
                {26'd0, 1'b1, 1'b1, 1'b0, IW'(i % N)});
            if (i == 0) chk("lfsr_fill_first", {28'd0, w_index1}, 32'h1);
            step();
        end
        idle_in();
        step();

        // single-cycle operations in IDLE
        for (int i = 0; i < 12; i++) begin
            op_valid = vt[i].v; op_code = vt[i].code; op_ex = vt[i].ex;
            inv_op = vt[i].iop; csr_index = vt[i].idx;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy_ill_we_clr_busy", i),
                {27'd0, op_ready, inv_ill, w_we, w_clear, busy},
                {27'd0, vt[i].rdy, vt[i].ill, vt[i].we, vt[i].clr, 1'b0});
            if (vt[i].we) chk($sformatf("vec%0d_widx", i), {28'd0, w_index},
                              {28'd0, vt[i].widx});
            chk($sformatf("vec%0d_ridx", i), {28'd0, r_index}, {28'd0, vt[i].ridx});
            step();
        end
        idle_in();
        step();

        // INVTLB sweeps
        run_inv("inv5", 5'd5, 10'd5, 19'h12345, 16'h1004);
        run_inv("inv2", 5'd2, 10'd0, 19'h0,     16'h0080);
        run_inv("inv6", 5'd6, 10'd5, 19'h12345, 16'h1084);
        run_inv("inv0", 5'd0, 10'd0, 19'h0,     16'h1894);
        run_inv("inv4", 5'd4, 10'd5, 19'h0,     16'h1804);

        // reset mid-sweep at counter 8
        load_model();
        m_e[8] = 1'b1;
        csr_index = 4'd3;
        op_valid = 1'b1; op_code = 3'd4; inv_op = 5'd0;
        step();
        idle_in();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k < 9) step();
        end
        chk("mid_pre_ridx_we", {27'd0, w_we, r_index}, {27'd0, 1'b1, 4'd8});
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_busy_we", {30'd0, busy, w_we}, 32'd0);
        chk("mid_reset_rdy", {31'd0, op_ready}, 32'd0);
        chk("mid_kept_cleared", {28'd0, m_e[2], m_e[7], m_e[8], m_e[11]},
            {28'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        step();
        step();
        reset = 1'b0;
        op_valid = 1'b1; op_code = 3'd2;
        @(negedge clk);
        chk("post_reset_fill", {26'd0, op_ready, w_we, w_clear, w_index},
            {26'd0, 1'b1, 1'b1, 1'b0, 4'd0});
        chk("post_reset_lfsr_fill", {28'd0, w_index1}, 32'h1);
        step();
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_maint_ctrl.md
TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries (power of two, 4..64); IW = log2(TLBNUM).
REQ-002 SHALL have parameter FILL_MODE, default 0, fill-index policy (0 round-robin, 1 LFSR pseudo-random).
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state rises on posedge clk
- reset  in  1  asynchronous, active-high
- op_valid  in  1  TLB maintenance instruction valid in write-back stage
- op_code  in  3  1 TLBWR, 2 TLBFILL, 3 TLBRD, 4 INVTLB, others none
- op_ex  in  1  instruction carries an exception; cancels op
- inv_op  in  5  INVTLB op field
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA[31:13] operand
- csr_index  in  IW  TLBIDX.index
- op_ready  out  1  op completes this cycle; stage may retire
- busy  out  1  INVTLB sweep in progress; write-back stalls
- inv_ill  out  1  one-cycle pulse: illegal inv_op retired
- w_we  out  1  TLB write-port enable
- w_index  out  IW  TLB write index
- w_clear  out  1  1: write E=0 (invalidate); 0: write data from CSRs
- r_index  out  IW  TLB read index
- r_e, r_g  in  1 each  read-port entry E, G
- r_asid  in  10  read-port ASID
- r_vppn  in  19  read-port VPPN
- r_ps  in  6  read-port page size (12 or 21)

Function
REQ-004 SHALL use FSM IDLE, SWEEP, DONE.
REQ-005 In IDLE, op_valid with op_ex=1 SHALL give op_ready=1 the same cycle, no write, no state change.
REQ-006 TLBWR in IDLE SHALL assert w_we=1, w_clear=0, w_index=csr_index, op_ready=1 the same cycle.
REQ-007 TLBFILL in IDLE SHALL assert w_we=1, w_clear=0, w_index=fill index, op_ready=1 the same cycle.
REQ-008 FILL_MODE=0: fill counter SHALL start at 0 and increment on each retired TLBFILL, wrapping TLBNUM-1 -> 0.
REQ-009 FILL_MODE=1: 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL reset to 16'hACE1 and advance every cycle; fill index = lfsr[IW-1:0].
REQ-010 TLBRD in IDLE SHALL drive r_index=csr_index and op_ready=1 the same cycle, no write.
REQ-011 Outside SWEEP, r_index SHALL equal csr_index.
REQ-012 INVTLB with inv_op 0..6 in IDLE SHALL enter SWEEP with sweep counter 0, latch inv_op/inv_asid/inv_vppn, op_ready=0.
REQ-013 Illegal inv_op (7..31) SHALL give op_ready=1 and inv_ill=1 the same cycle, no writes.
REQ-014 In SWEEP, r_index SHALL equal the counter; match computed combinationally on r_* the same cycle.
REQ-015 Match, with VA match = r_vppn[18:9]==vppn[18:9] when r_ps=21, full 19-bit equal otherwise:
- op 0/1: all entries
- op 2: r_g=1
- op 3: r_g=0
- op 4: r_g=0 and r_asid==asid
- op 5: op-4 condition and VA match
- op 6: (r_g=1 or r_asid==asid) and VA match
Every match also requires r_e=1.
REQ-016 On match SHALL assert w_we=1, w_clear=1, w_index=counter that cycle.
REQ-017 Counter SHALL increment each SWEEP cycle; at TLBNUM-1 SHALL go to DONE.
REQ-018 DONE SHALL assert op_ready=1 for one cycle, then return to IDLE.
REQ-019 INVTLB latency SHALL be TLBNUM+1 cycles from acceptance to op_ready.
REQ-020 busy SHALL be 1 in SWEEP and DONE; op_valid/op_code ignored while busy.
REQ-021 w_we SHALL never assert for more than one index per cycle.

Reset
REQ-022 Reset SHALL asynchronously force: state IDLE, sweep counter 0, fill counter 0, LFSR 16'hACE1, busy=0, inv_ill=0, w_we=0, w_clear=0.
REQ-023 Reset mid-SWEEP SHALL abort immediately, leaving entries already cleared; no op_ready issued.

Verification
REQ-024 TLBNUM=16, FILL_MODE=0, 17 TLBFILLs -> w_index 0,1,..,15,0; w_we=1 each, w_clear=0.
REQ-025 TLBWR, csr_index=3 -> w_we=1, w_index=3, op_ready=1 same cycle.
REQ-026 Entries 2 (G=0, ASID 5, VPPN 0x12345) and 7 (G=1, same VPPN), INVTLB op 5, asid 5, vppn 0x12345 -> only index 2 cleared; op_ready 17 cycles after acceptance.
REQ-027 INVTLB inv_op=9 -> op_ready=1, inv_ill=1 same cycle, w_we=0, busy=0.
REQ-028 Reset asserted at sweep counter 8 -> busy=0 and w_we=0 immediately; later TLBFILL uses index 0.
REQ-029 FILL_MODE=1, TLBFILL first cycle after reset -> w_index=4'h1 (0xACE1 low bits).
